i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Serializes stereo PCM sample pairs onto an I2S link to the audio codec. Sits directly downstream of the clock divider and the FIR output stage. It consumes the divided bit clock as a plain signal sampled in the system clock domain, and accepts left/right samples through a valid/ready holding register. It drives the codec's BCLK, LRCK and SDATA pins, all phase-aligned to one system-clock edge.

## Interface
- DATA_WD, default 16: sample width per channel; slot width equals DATA_WD.
- clk_i  in  1  system clock; the only clock. bclk_i is a data signal in this domain.
- rst_i  in  1  synchronous, active-high reset.
- bclk_i  in  1  divided bit clock from the clock divider; each phase is at least 2 clk_i cycles.
- l_data_i  in  DATA_WD  left sample, two's complement.
- r_data_i  in  DATA_WD  right sample, two's complement.
- valid_i  in  1  sample pair valid.
- ready_o  out  1  holding register empty; transfer occurs on valid_i & ready_o.
- bclk_o  out  1  registered copy of bclk_i, one clk_i delay.
- lrck_o  out  1  word select; 0 = left slot, 1 = right slot.
- sdata_o  out  1  serial data, MSB first.
- frame_o  out  1  one-cycle pulse when a frame is loaded into the shifter.
- underrun_o  out  1  one-cycle pulse when a frame starts with the holding register empty.

## Operation
- Edge detect: bclk_d <= bclk_i each cycle. fall = bclk_d & ~bclk_i. bclk_o = bclk_d.
- Holding register: hold (2*DATA_WD bits) and hold_full. ready_o = ~hold_full & ~rst_i.
  - Accepting a pair sets hold <= {l_data_i, r_data_i} and hold_full <= 1.
- Shifter: shreg (2*DATA_WD bits). Bit counter k runs 0..2*DATA_WD-1 and wraps to 0.
- FSM IDLE:
  - sdata_o = 0, lrck_o = 0, k = 0.
  - On fall with hold_full = 1: load the frame as k = 0 (see below), then go to RUN.
  - A fall with hold_full = 0 in IDLE causes no underrun pulse.
- FSM RUN, on every fall:
  - k = 0:
    - If hold_full: shreg <= hold, clear hold_full, pulse frame_o.
    - Otherwise: pulse underrun_o and load the fallback frame (see Configuration), with frame_o still pulsed.
    - sdata_o <= MSB of the loaded frame.
  - k != 0: sdata_o <= shreg bit (2*DATA_WD-1-k).
  - lrck_o <= 1 when ((k+1) mod 2*DATA_WD) >= DATA_WD, else 0. lrck therefore leads each slot's MSB by one BCLK (standard I2S).
  - k <= k+1, wrapping to 0 after 2*DATA_WD-1.
- Simultaneous accept and k = 0 load in the same cycle: the frame underruns. The accepted pair stays in hold for the next frame.
- Reset at any time: return to IDLE, drop hold contents, clear shreg and k.

## Timing
- Reset values: bclk_o = 0, lrck_o = 0, sdata_o = 0, frame_o = 0, underrun_o = 0, ready_o = 0 while rst_i is high and 1 on the first cycle after.
- sdata_o, lrck_o, frame_o, underrun_o and bclk_o's falling transition all update on the same clk_i edge, one clk_i after bclk_i falls.
- Sample-to-pin latency: a pair accepted before the k = 0 fall appears MSB-first starting at that fall. Worst case is one frame (2*DATA_WD BCLK periods) of waiting in hold.
- Rising edges of bclk_i change only bclk_o.
- Throughput: one pair per 2*DATA_WD BCLK periods. ready_o rises the cycle after the load.

## Configuration
- I2S_TX_UNDERRUN_REPEAT_EN defined: on underrun the shifter reloads the last successfully transmitted pair (zeros if none since reset).
- Undefined: on underrun the shifter loads all zeros (silence).
- underrun_o pulses identically in both builds.

## Test plan
- Reset release, DATA_WD = 16, bclk_i 4 high / 4 low clk_i, no valid_i:
  - Required: outputs stay 0, ready_o = 1 after reset, no frame_o or underrun_o.
- Pair L = 16'hA5C3, R = 16'h8001 presented once in IDLE:
  - Required: frame_o at the next fall.
  - sdata_o sequence over 32 falls is A5C3 then 8001, MSB first.
  - lrck_o = 1 on falls k = 15..30.
  - bclk_o falls in the same cycle as each sdata_o change.
- Continuous valid_i with an incrementing pattern:
  - Required: back-to-back frames, one frame_o per 32 falls, no underrun_o.
  - Each ready_o deassert lasts until the next k = 0 load.
- Stall valid_i after one frame:
  - Required: underrun_o at the next k = 0.
  - Payload is zeros, or A5C3/8001 repeated with I2S_TX_UNDERRUN_REPEAT_EN.
- valid_i asserted in the exact cycle of the k = 0 fall with hold empty:
  - Required: underrun_o for that frame, and the pair is transmitted in the following frame.
- rst_i pulsed at k = 20:
  - Required: outputs 0 the next cycle, state IDLE, hold empty.
  - The next accepted pair restarts at k = 0.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: a one-deep valid/ready hold register feeds a 2*DATA_WD shifter. Pins update one clk_i after bclk_i falls; ready_o stays low while a pair waits.
// Optional macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun, replay the last pair instead of sending silence.
module i2s_tx_serializer #(
  parameter int DATA_WD = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bclk_i,
  input  logic [DATA_WD-1:0] l_data_i,
  input  logic [DATA_WD-1:0] r_data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               bclk_o,
  output logic               lrck_o,
  output logic               sdata_o,
  output logic               frame_o,
  output logic               underrun_o
);
  localparam int FW = 2 * DATA_WD;
  localparam int KW = $clog2(FW);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state;
  logic          r_bclk_d;
  logic          r_hold_full;
  logic          r_sdata;
  logic          r_lrck;
  logic          r_frame;
  logic          r_underrun;
  logic [FW-1:0] r_hold;
  logic [FW-1:0] r_shreg;
  logic [KW-1:0] r_k;

  logic          w_fall;
  logic          w_accept;
  logic          w_lrck_next;
  logic [KW-1:0] w_k_next;
  logic [KW-1:0] w_idx;
  logic [FW-1:0] w_fallback;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FW-1:0] r_last;
  assign w_fallback = r_last;
`else
  assign w_fallback = '0;
`endif

  assign w_fall      = r_bclk_d & ~bclk_i;
  assign ready_o     = ~r_hold_full & ~rst_i;
  assign w_accept    = valid_i & ready_o;
  assign w_k_next    = (r_k == KW'(FW - 1)) ? '0 : r_k + KW'(1);
  // lrck switches one bit ahead of each slot's MSB
  assign w_lrck_next = (w_k_next >= KW'(DATA_WD));
  assign w_idx       = KW'(FW - 1) - r_k;

  assign bclk_o     = r_bclk_d;
  assign lrck_o     = r_lrck;
  assign sdata_o    = r_sdata;
  assign frame_o    = r_frame;
  assign underrun_o = r_underrun;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_bclk_d    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shreg     <= '0;
      r_k         <= '0;
      r_sdata     <= 1'b0;
      r_lrck      <= 1'b0;
      r_frame     <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      r_last      <= '0;
`endif
    end else begin
      r_bclk_d   <= bclk_i;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      // accept and load never overlap on hold_full: accept needs it clear, load needs it set
      if (w_accept) begin
        r_hold      <= {l_data_i, r_data_i};
        r_hold_full <= 1'b1;
      end
      if (w_fall && (r_state == ST_RUN || r_hold_full)) begin
        r_state <= ST_RUN;
        r_lrck  <= w_lrck_next;
        r_k     <= w_k_next;
        if (r_k == '0) begin
          r_frame <= 1'b1;
          if (r_hold_full) begin
            r_shreg     <= r_hold;
            r_sdata     <= r_hold[FW-1];
            r_hold_full <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            r_last      <= r_hold;
`endif
          end else begin
            r_shreg    <= w_fallback;
            r_sdata    <= w_fallback[FW-1];
            r_underrun <= 1'b1;
          end
        end else begin
          r_sdata <= r_shreg[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer (DATA_WD = 16, bclk_i 4 clk high / 4 clk low).
// Build with I2S_TX_UNDERRUN_REPEAT_EN defined to expect the repeat-on-underrun payload.
module tb_i2s_tx_serializer;
  localparam int DW = 16;
  localparam logic [31:0] LR_EXP = 32'h0001_FFFE;

  typedef struct packed {
    logic [31:0] bits;
    logic [31:0] lr;
    logic        ur;
  } frm_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          bclk_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] l_data_i = '0;
  logic [DW-1:0] r_data_i = '0;
  logic          ready_o, bclk_o, lrck_o, sdata_o, frame_o, underrun_o;

  int   n_checks = 0;
  int   n_fail = 0;
  frm_t exp_q[$];
  frm_t obs_q[$];
  logic [31:0] m_last = '0;

  int          n_frames = 0, n_under = 0, misalign = 0, ready_err = 0;
  logic        cap_act = 1'b0;
  int          cap_k = 0;
  logic [31:0] cap_bits = '0, cap_lr = '0;
  logic        cap_ur = 1'b0;
  logic        p_bclk = 1'b0, p_sdata = 1'b0, p_lrck = 1'b0, p_ready = 1'b0, p_rst = 1'b1;

  i2s_tx_serializer #(.DATA_WD(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .bclk_i(bclk_i),
    .l_data_i(l_data_i), .r_data_i(r_data_i), .valid_i(valid_i),
    .ready_o(ready_o), .bclk_o(bclk_o), .lrck_o(lrck_o), .sdata_o(sdata_o),
    .frame_o(frame_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 bclk_i = ~bclk_i;
    end
  end

  // Output capture: rebuilds each frame from sdata/lrck on every bclk_o fall.
  always @(negedge clk) begin : capture
    logic fall;
    fall = p_bclk & ~bclk_o;
    if (rst_i) begin
      cap_act = 1'b0;
    end else begin
      if (!p_rst) begin
        if (((sdata_o !== p_sdata) || (lrck_o !== p_lrck) || frame_o || underrun_o) && !fall)
          misalign++;
        if (ready_o && !p_ready && !frame_o) ready_err++;
      end
      if (frame_o) begin
        cap_act = 1'b1; cap_k = 0; cap_bits = '0; cap_lr = '0; cap_ur = underrun_o;
        n_frames++;
      end
      if (underrun_o) n_under++;
      if (cap_act && fall) begin
        cap_bits[31-cap_k] = sdata_o;
        cap_lr[31-cap_k]   = lrck_o;
        cap_k++;
        if (cap_k == 32) begin
          obs_q.push_back({cap_bits, cap_lr, cap_ur});
          cap_act = 1'b0;
        end
      end
    end
    p_bclk = bclk_o; p_sdata = sdata_o; p_lrck = lrck_o; p_ready = ready_o; p_rst = rst_i;
  end

  function automatic logic [31:0] fb_payload();
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    return m_last;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_exp(input logic [31:0] bits, input logic ur);
    exp_q.push_back({bits, LR_EXP, ur});
    if (!ur) m_last = bits;
  endtask

  task automatic clear_model();
    exp_q.delete(); obs_q.delete(); m_last = '0;
    n_frames = 0; n_under = 0; misalign = 0; ready_err = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_i = 1'b1; valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    clear_model();
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    l_data_i = l; r_data_i = r; valid_i = 1'b1;
    @(negedge clk);
    while (ready_o !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (ready_o !== 1'b1) begin
      $display("FAIL send_ready_timeout: ready_o=%b required 1", ready_o);
      n_fail++;
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
    push_exp({l, r}, 1'b0);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int t = 0;
    while (obs_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    bit bad = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b required 000000",
               {bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o});
      n_fail++;
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    clear_model();
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1) begin
      $display("FAIL reset_ready_after: got %b required 1", ready_o); n_fail++;
    end
    repeat (100) begin
      @(negedge clk);
      if (sdata_o !== 1'b0 || lrck_o !== 1'b0) bad = 1;
    end
    n_checks += 3;
    if (bad) begin $display("FAIL reset_idle_pins: sdata/lrck went nonzero, required 0"); n_fail++; end
    if (n_frames != 0) begin $display("FAIL reset_no_frame: got %0d required 0", n_frames); n_fail++; end
    if (n_under != 0) begin $display("FAIL reset_no_underrun: got %0d required 0", n_under); n_fail++; end
  endtask

  task automatic test_single_and_stall();
    int t = 0;
    bit ok;
    int idx = 0;
    frm_t e, o;
    apply_reset();
    send_pair(16'hA5C3, 16'h8001);
    do begin
      @(negedge clk);
      t++;
    end while (frame_o !== 1'b1 && t < 20);
    n_checks++;
    if (frame_o !== 1'b1 || t > 8) begin
      $display("FAIL single_frame_latency: frame_o after %0d cycles, required within 8", t); n_fail++;
    end
    push_exp(fb_payload(), 1'b1);
    wait_obs(2, ok);
    n_checks++;
    if (!ok) begin $display("FAIL single_timeout: got %0d frames required 2", obs_q.size()); n_fail++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 3;
      if (o.bits !== e.bits) begin $display("FAIL single_bits[%0d]: got %h required %h", idx, o.bits, e.bits); n_fail++; end
      if (o.lr !== LR_EXP) begin $display("FAIL single_lrck[%0d]: got %h required %h", idx, o.lr, LR_EXP); n_fail++; end
      if (o.ur !== e.ur) begin $display("FAIL single_underrun[%0d]: got %b required %b", idx, o.ur, e.ur); n_fail++; end
      idx++;
    end
    n_checks += 3;
    if (n_under != 1) begin $display("FAIL stall_underrun_count: got %0d required 1", n_under); n_fail++; end
    if (misalign != 0) begin $display("FAIL single_align: got %0d off-edge changes required 0", misalign); n_fail++; end
    if (ready_err != 0) begin $display("FAIL single_ready_rise: got %0d early rises required 0", ready_err); n_fail++; end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int idx = 0;
    frm_t e, o;
    apply_reset();
    for (int i = 0; i < 4; i++) send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    wait_obs(4, ok);
    n_checks++;
    if (!ok) begin $display("FAIL b2b_timeout: got %0d frames required 4", obs_q.size()); n_fail++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 2;
      if (o.bits !== e.bits) begin $display("FAIL b2b_bits[%0d]: got %h required %h", idx, o.bits, e.bits); n_fail++; end
      if (o.ur !== e.ur) begin $display("FAIL b2b_underrun[%0d]: got %b required %b", idx, o.ur, e.ur); n_fail++; end
      idx++;
    end
    n_checks += 4;
    if (n_frames != 4) begin $display("FAIL b2b_frames: got %0d required 4", n_frames); n_fail++; end
    if (n_under != 0) begin $display("FAIL b2b_no_underrun: got %0d required 0", n_under); n_fail++; end
    if (ready_err != 0) begin $display("FAIL b2b_ready_rise: got %0d early rises required 0", ready_err); n_fail++; end
    if (misalign != 0) begin $display("FAIL b2b_align: got %0d off-edge changes required 0", misalign); n_fail++; end
  endtask

  task automatic test_valid_at_k0();
    int t = 0;
    bit ok;
    int idx = 0;
    frm_t e, o;
    apply_reset();
    send_pair(16'h1234, 16'hFEDC);
    do begin
      @(negedge clk);
      t++;
    end while (frame_o !== 1'b1 && t < 20);
    // next k = 0 fall lands 32 bclk periods (256 clk) after this frame_o
    repeat (255) @(posedge clk);
    #1 l_data_i = 16'h0F0F; r_data_i = 16'h7001; valid_i = 1'b1;
    n_checks++;
    if (ready_o !== 1'b1) begin $display("FAIL k0_ready: got %b required 1", ready_o); n_fail++; end
    @(posedge clk);
    #1 valid_i = 1'b0;
    push_exp(fb_payload(), 1'b1);
    push_exp({16'h0F0F, 16'h7001}, 1'b0);
    wait_obs(3, ok);
    n_checks++;
    if (!ok) begin $display("FAIL k0_timeout: got %0d frames required 3", obs_q.size()); n_fail++; end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 2;
      if (o.bits !== e.bits) begin $display("FAIL k0_bits[%0d]: got %h required %h", idx, o.bits, e.bits); n_fail++; end
      if (o.ur !== e.ur) begin $display("FAIL k0_underrun[%0d]: got %b required %b", idx, o.ur, e.ur); n_fail++; end
      idx++;
    end
    n_checks++;
    if (n_under != 1) begin $display("FAIL k0_underrun_count: got %0d required 1", n_under); n_fail++; end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bit ok;
    frm_t e, o;
    apply_reset();
    send_pair(16'hC001, 16'h00FF);
    do begin
      @(negedge clk);
      t++;
    end while (frame_o !== 1'b1 && t < 20);
    @(posedge clk);
    #1 l_data_i = 16'hBEEF; r_data_i = 16'hCAFE; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (157) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o} !== 6'b0) begin
      $display("FAIL midreset_outputs: got %b required 000000",
               {bclk_o, lrck_o, sdata_o, frame_o, underrun_o, ready_o});
      n_fail++;
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    clear_model();
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b1) begin $display("FAIL midreset_hold_empty: ready_o=%b required 1", ready_o); n_fail++; end
    repeat (64) @(negedge clk);
    n_checks++;
    if (n_frames != 0) begin $display("FAIL midreset_idle: got %0d frames required 0", n_frames); n_fail++; end
    send_pair(16'h4321, 16'h8765);
    wait_obs(1, ok);
    n_checks++;
    if (!ok) begin $display("FAIL midreset_timeout: got %0d frames required 1", obs_q.size()); n_fail++; end
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 3;
      if (o.bits !== e.bits) begin $display("FAIL midreset_bits: got %h required %h", o.bits, e.bits); n_fail++; end
      if (o.lr !== LR_EXP) begin $display("FAIL midreset_lrck: got %h required %h", o.lr, LR_EXP); n_fail++; end
      if (o.ur !== 1'b0) begin $display("FAIL midreset_underrun: got %b required 0", o.ur); n_fail++; end
    end
    n_checks++;
    if (misalign != 0) begin $display("FAIL midreset_align: got %0d off-edge changes required 0", misalign); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_single_and_stall();
    test_back_to_back();
    test_valid_at_k0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
